// File: rtl/pipe_ctrl_unit.sv
// Pipelined RV32I-subset control: ID decode, ID/EX, EX/MEM and MEM/WB bundles,
// hazard stalls, redirect flushes, forwarding selects and a memory freeze.
module pipe_ctrl_unit #(
    parameter int REG_AW   = 5,
    parameter int MEM_WAIT = 0,
    parameter int FWD_EN   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_redirect,
    output logic              stall_if_id,
    output logic              flush_if_id,
    output logic              illegal,
    output logic [3:0]        ex_aluop,
    output logic              ex_alusrc,
    output logic              ex_beq,
    output logic              ex_bge,
    output logic              ex_jal,
    output logic              ex_jalr,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_busy,
    output logic              wb_regwrite,
    output logic [1:0]        wb_memtoreg,
    output logic [REG_AW-1:0] wb_rd
);

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3, ALU_XOR = 4'd4, ALU_SLT = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6, ALU_SRL = 4'd7, ALU_SRA = 4'd8;
    localparam logic [3:0] ALU_PB  = 4'd9;
    localparam logic [3:0] WAIT_CNT = 4'(MEM_WAIT);

    typedef struct packed {
        logic [3:0] aluop;
        logic       alusrc;
        logic       beq;
        logic       bge;
        logic       jal;
        logic       jalr;
        logic       rd_mem;
        logic       wr_mem;
        logic       regwrite;
        logic [1:0] memtoreg;
    } ctrl_t;

    function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
        unique case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLT;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic src_hit(
        input logic [REG_AW-1:0] rd,
        input logic u1, input logic [REG_AW-1:0] r1,
        input logic u2, input logic [REG_AW-1:0] r2
    );
        return (rd != '0) && ((u1 && rd == r1) || (u2 && rd == r2));
    endfunction

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs, input logic used,
        input logic m_ok, input logic [REG_AW-1:0] m_rd,
        input logic w_ok, input logic [REG_AW-1:0] w_rd
    );
        if (!used || rs == '0) return 2'b00;
        if (m_ok && m_rd == rs) return 2'b10;
        if (w_ok && w_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    ctrl_t d_ctrl, id_ctrl, ex_ctrl_q;
    logic d_legal, d_use1, d_use2;
    logic ex_v_q, ex_use1_q, ex_use2_q;
    logic [REG_AW-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
    logic mem_v_q, mem_rdm_q, mem_wrm_q, mem_wr_q;
    logic [1:0] mem_m2r_q;
    logic [REG_AW-1:0] mem_rd_q;
    logic wb_v_q, wb_wr_q;
    logic [1:0] wb_m2r_q;
    logic [REG_AW-1:0] wb_rd_q;
    logic [3:0] cnt_q, cnt_d;
    logic frozen, flush, haz, lu_haz, raw_haz, ex_v_d, id_u1, id_u2;
    logic unused_func7;

    assign unused_func7 = ^{func7[6], func7[4:0]};

    always_comb begin
        d_ctrl  = '0;
        d_legal = 1'b0;
        d_use1  = 1'b0;
        d_use2  = 1'b0;
        unique case (opcode)
            7'b0000011: begin
                d_legal = 1'b1; d_use1 = 1'b1;
                d_ctrl.alusrc = 1'b1; d_ctrl.rd_mem = 1'b1;
                d_ctrl.regwrite = 1'b1; d_ctrl.memtoreg = 2'b01;
            end
            7'b0100011: begin
                d_legal = 1'b1; d_use1 = 1'b1; d_use2 = 1'b1;
                d_ctrl.alusrc = 1'b1; d_ctrl.wr_mem = 1'b1;
            end
            7'b0010011: begin
                d_legal = 1'b1; d_use1 = 1'b1;
                d_ctrl.alusrc = 1'b1; d_ctrl.regwrite = 1'b1;
                d_ctrl.aluop = alu_map(func3, func3 == 3'b101 && func7[5]);
            end
            7'b0110011: begin
                d_legal = 1'b1; d_use1 = 1'b1; d_use2 = 1'b1;
                d_ctrl.regwrite = 1'b1;
                d_ctrl.aluop = alu_map(func3, func7[5]);
            end
            7'b1100011: begin
                d_legal = (func3 == 3'b000) || (func3 == 3'b101);
                d_use1 = d_legal; d_use2 = d_legal;
                d_ctrl.beq = (func3 == 3'b000);
                d_ctrl.bge = (func3 == 3'b101);
                d_ctrl.aluop = ALU_SUB;
            end
            7'b1101111: begin
                d_legal = 1'b1;
                d_ctrl.jal = 1'b1; d_ctrl.regwrite = 1'b1;
                d_ctrl.memtoreg = 2'b10;
            end
            7'b1100111: begin
                d_legal = 1'b1; d_use1 = 1'b1;
                d_ctrl.jalr = 1'b1; d_ctrl.alusrc = 1'b1;
                d_ctrl.regwrite = 1'b1; d_ctrl.memtoreg = 2'b10;
            end
            7'b0110111: begin
                d_legal = 1'b1;
                d_ctrl.alusrc = 1'b1; d_ctrl.regwrite = 1'b1;
                d_ctrl.aluop = ALU_PB;
            end
            default: d_legal = 1'b0;
        endcase
    end

    always_comb begin
        id_ctrl = d_ctrl;
        id_ctrl.regwrite = d_ctrl.regwrite && (id_rd != '0);
    end

    assign id_u1   = id_valid & d_use1;
    assign id_u2   = id_valid & d_use2;
    assign illegal = id_valid & ~d_legal;

    assign lu_haz = ex_v_q & ex_ctrl_q.rd_mem &
                    src_hit(ex_rd_q, id_u1, id_rs1, id_u2, id_rs2);
    assign raw_haz =
        (ex_v_q & ex_ctrl_q.regwrite &
         src_hit(ex_rd_q, id_u1, id_rs1, id_u2, id_rs2)) |
        (mem_v_q & mem_wr_q &
         src_hit(mem_rd_q, id_u1, id_rs1, id_u2, id_rs2)) |
        (wb_v_q & wb_wr_q &
         src_hit(wb_rd_q, id_u1, id_rs1, id_u2, id_rs2));
    assign haz = (FWD_EN != 0) ? lu_haz : raw_haz;

    // A frozen EX cannot redirect; it re-presents the redirect once MEM drains.
    assign frozen      = (cnt_q != 4'd0);
    assign flush       = ex_redirect & ~frozen;
    assign stall_if_id = frozen | (haz & ~flush);
    assign flush_if_id = flush;
    assign mem_busy    = frozen;
    assign ex_v_d      = id_valid & d_legal & ~haz & ~flush;

    always_comb begin
        cnt_d = 4'd0;
        if (frozen) cnt_d = cnt_q - 4'd1;
        else if (ex_v_q && (ex_ctrl_q.rd_mem || ex_ctrl_q.wr_mem)) cnt_d = WAIT_CNT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_v_q    <= 1'b0;
            ex_ctrl_q <= '0;
            ex_use1_q <= 1'b0;
            ex_use2_q <= 1'b0;
            ex_rd_q   <= '0;
            ex_rs1_q  <= '0;
            ex_rs2_q  <= '0;
            mem_v_q   <= 1'b0;
            mem_rdm_q <= 1'b0;
            mem_wrm_q <= 1'b0;
            mem_wr_q  <= 1'b0;
            mem_m2r_q <= 2'b00;
            mem_rd_q  <= '0;
            wb_v_q    <= 1'b0;
            wb_wr_q   <= 1'b0;
            wb_m2r_q  <= 2'b00;
            wb_rd_q   <= '0;
            cnt_q     <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
            if (!frozen) begin
                ex_v_q    <= ex_v_d;
                ex_ctrl_q <= id_ctrl;
                ex_use1_q <= d_use1;
                ex_use2_q <= d_use2;
                ex_rd_q   <= id_rd;
                ex_rs1_q  <= id_rs1;
                ex_rs2_q  <= id_rs2;
                mem_v_q   <= ex_v_q;
                mem_rdm_q <= ex_ctrl_q.rd_mem;
                mem_wrm_q <= ex_ctrl_q.wr_mem;
                mem_wr_q  <= ex_ctrl_q.regwrite;
                mem_m2r_q <= ex_ctrl_q.memtoreg;
                mem_rd_q  <= ex_rd_q;
                wb_v_q    <= mem_v_q;
                wb_wr_q   <= mem_wr_q;
                wb_m2r_q  <= mem_m2r_q;
                wb_rd_q   <= mem_rd_q;
            end
        end
    end

    assign ex_aluop  = ex_v_q ? ex_ctrl_q.aluop : 4'd0;
    assign ex_alusrc = ex_v_q & ex_ctrl_q.alusrc;
    assign ex_beq    = ex_v_q & ex_ctrl_q.beq;
    assign ex_bge    = ex_v_q & ex_ctrl_q.bge;
    assign ex_jal    = ex_v_q & ex_ctrl_q.jal;
    assign ex_jalr   = ex_v_q & ex_ctrl_q.jalr;

    // Loads in EX/MEM have no data yet; they reach EX only via MEM/WB.
    assign fwd_a = (FWD_EN != 0) ?
        fwd_sel(ex_rs1_q, ex_v_q & ex_use1_q,
                mem_v_q & mem_wr_q & ~mem_rdm_q, mem_rd_q,
                wb_v_q & wb_wr_q, wb_rd_q) : 2'b00;
    assign fwd_b = (FWD_EN != 0) ?
        fwd_sel(ex_rs2_q, ex_v_q & ex_use2_q,
                mem_v_q & mem_wr_q & ~mem_rdm_q, mem_rd_q,
                wb_v_q & wb_wr_q, wb_rd_q) : 2'b00;

    assign mem_read    = mem_v_q & mem_rdm_q;
    assign mem_write   = mem_v_q & mem_wrm_q;
    assign wb_regwrite = wb_v_q & wb_wr_q;
    assign wb_memtoreg = wb_v_q ? wb_m2r_q : 2'b00;
    assign wb_rd       = wb_v_q ? wb_rd_q : '0;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: three instances (default, MEM_WAIT=3, FWD_EN=0)
// share stimulus; each section checks the instance it targets.
module tb_pipe_ctrl_unit;

    localparam int MW [3] = '{0, 3, 0};
    localparam int FE [3] = '{1, 1, 0};

    localparam logic [6:0] OP_LW  = 7'b0000011, OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_I   = 7'b0010011, OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BR  = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111, OP_LUI = 7'b0110111;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic id_valid = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] func3 = 3'd0;
    logic [6:0] func7 = 7'd0;
    logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
    logic ex_redirect = 1'b0;

    logic stall [3], flush [3], ill [3];
    logic [3:0] aluop [3];
    logic src [3], beq [3], bge [3], jal [3], jalr [3];
    logic [1:0] fa [3], fb [3];
    logic mrd [3], mwr [3], busy [3], rw [3];
    logic [1:0] m2r [3];
    logic [4:0] wrd [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pipe_ctrl_unit #(.REG_AW(5), .MEM_WAIT(MW[g]), .FWD_EN(FE[g])) u_dut (
            .clk(clk), .reset(reset), .id_valid(id_valid),
            .opcode(opcode), .func3(func3), .func7(func7),
            .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
            .ex_redirect(ex_redirect),
            .stall_if_id(stall[g]), .flush_if_id(flush[g]), .illegal(ill[g]),
            .ex_aluop(aluop[g]), .ex_alusrc(src[g]), .ex_beq(beq[g]),
            .ex_bge(bge[g]), .ex_jal(jal[g]), .ex_jalr(jalr[g]),
            .fwd_a(fa[g]), .fwd_b(fb[g]),
            .mem_read(mrd[g]), .mem_write(mwr[g]), .mem_busy(busy[g]),
            .wb_regwrite(rw[g]), .wb_memtoreg(m2r[g]), .wb_rd(wrd[g])
        );
    end

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] alu;
        logic [5:0] fl;
    } dvec_t;

    typedef struct {
        logic [3:0] alu;
        logic [4:0] fl;
    } exp_t;

    int nvec = 0;
    int nerr = 0;
    dvec_t tbl [22];
    exp_t sbq [$];

    function automatic dvec_t mk(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [3:0] alu,
                                 input logic [5:0] fl);
        dvec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.alu = alu; v.fl = fl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd,
                         input logic v);
        opcode = op; func3 = f3; func7 = f7;
        id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_valid = v;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; id_valid = 1'b0; ex_redirect = 1'b0;
        nxt(); nxt();
        reset = 1'b0;
    endtask

    initial begin
        logic [8:0] eb, er, ew;
        exp_t e;

        tbl[0]  = mk(OP_R,   3'b000, 7'h00, 4'd0, 6'b000000);
        tbl[1]  = mk(OP_R,   3'b000, 7'h20, 4'd1, 6'b000000);
        tbl[2]  = mk(OP_I,   3'b101, 7'h20, 4'd8, 6'b100000);
        tbl[3]  = mk(OP_LUI, 3'b000, 7'h00, 4'd9, 6'b100000);
        tbl[4]  = mk(OP_BR,  3'b101, 7'h00, 4'd1, 6'b001000);
        tbl[5]  = mk(7'h7F,  3'b000, 7'h00, 4'd0, 6'b000001);
        tbl[6]  = mk(OP_I,   3'b000, 7'h20, 4'd0, 6'b100000);
        tbl[7]  = mk(OP_BR,  3'b000, 7'h00, 4'd1, 6'b010000);
        tbl[8]  = mk(OP_BR,  3'b001, 7'h00, 4'd0, 6'b000001);
        tbl[9]  = mk(OP_JAL, 3'b000, 7'h00, 4'd0, 6'b000100);
        tbl[10] = mk(OP_JR,  3'b000, 7'h00, 4'd0, 6'b100010);
        tbl[11] = mk(OP_LW,  3'b010, 7'h00, 4'd0, 6'b100000);
        tbl[12] = mk(OP_SW,  3'b010, 7'h00, 4'd0, 6'b100000);
        tbl[13] = mk(OP_R,   3'b111, 7'h00, 4'd2, 6'b000000);
        tbl[14] = mk(OP_R,   3'b101, 7'h00, 4'd7, 6'b000000);
        tbl[15] = mk(OP_I,   3'b001, 7'h00, 4'd6, 6'b100000);
        tbl[16] = mk(OP_R,   3'b100, 7'h00, 4'd4, 6'b000000);
        tbl[17] = mk(OP_R,   3'b110, 7'h00, 4'd3, 6'b000000);
        tbl[18] = mk(OP_R,   3'b010, 7'h00, 4'd5, 6'b000000);
        tbl[19] = mk(OP_I,   3'b101, 7'h00, 4'd7, 6'b100000);
        tbl[20] = mk(OP_R,   3'b101, 7'h20, 4'd8, 6'b000000);
        tbl[21] = mk(7'b0010111, 3'b000, 7'h00, 4'd0, 6'b000001);

        // reset held two cycles with a real instruction present
        drive(OP_R, 3'b000, 7'h00, 5'd1, 5'd1, 5'd1, 1'b1);
        nxt(); nxt();
        smp();
        chk("rst_stall", 32'(stall[0]), 32'd0);
        chk("rst_flush", 32'(flush[0]), 32'd0);
        chk("rst_illegal", 32'(ill[0]), 32'd0);
        chk("rst_aluop", 32'(aluop[0]), 32'd0);
        chk("rst_alusrc", 32'(src[0]), 32'd0);
        chk("rst_fwd", 32'({fa[0], fb[0]}), 32'd0);
        chk("rst_mem", 32'({mrd[0], mwr[0]}), 32'd0);
        chk("rst_busy", 32'({busy[0], busy[1], busy[2]}), 32'd0);
        chk("rst_wb", 32'({rw[0], m2r[0], wrd[0]}), 32'd0);

        // decode table through the scoreboard: ID now, EX one cycle later
        do_reset();
        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].op, tbl[i].f3, tbl[i].f7, 5'd2, 5'd3, 5'd1, 1'b1);
            smp();
            chk($sformatf("dec%0d_illegal", i), 32'(ill[0]), 32'(tbl[i].fl[0]));
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk($sformatf("dec%0d_aluop", i - 1), 32'(aluop[0]), 32'(e.alu));
                chk($sformatf("dec%0d_flags", i - 1),
                    32'({src[0], beq[0], bge[0], jal[0], jalr[0]}), 32'(e.fl));
            end
            e.alu = tbl[i].alu;
            e.fl  = tbl[i].fl[5:1];
            sbq.push_back(e);
            nxt();
        end
        drive(7'h7F, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        smp();
        chk("dec_invalid_not_illegal", 32'(ill[0]), 32'd0);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("dec_last_aluop", 32'(aluop[0]), 32'(e.alu));
            chk("dec_last_flags",
                32'({src[0], beq[0], bge[0], jal[0], jalr[0]}), 32'(e.fl));
        end
        nxt();

        // load-use, forwarding from EX/MEM and MEM/WB, x0 never forwards
        do_reset();
        drive(OP_LW, 3'b010, 7'h00, 5'd1, 5'd0, 5'd5, 1'b1);
        smp(); nxt();
        drive(OP_R, 3'b000, 7'h00, 5'd5, 5'd1, 5'd6, 1'b1);
        smp();
        chk("lu_stall", 32'(stall[0]), 32'd1);
        chk("lu_flush", 32'(flush[0]), 32'd0);
        nxt();
        smp();
        chk("lu_stall_one_cycle", 32'(stall[0]), 32'd0);
        nxt();
        drive(OP_R, 3'b000, 7'h00, 5'd2, 5'd3, 5'd5, 1'b1);
        smp();
        chk("lu_fwd_a", 32'(fa[0]), 32'd1);
        chk("lu_fwd_b", 32'(fb[0]), 32'd0);
        chk("lu_wb", 32'({rw[0], m2r[0], wrd[0]}), 32'({1'b1, 2'b01, 5'd5}));
        nxt();
        drive(OP_R, 3'b000, 7'h00, 5'd5, 5'd0, 5'd7, 1'b1);
        smp();
        chk("alu_dep_no_stall", 32'(stall[0]), 32'd0);
        nxt();
        drive(OP_R, 3'b000, 7'h00, 5'd1, 5'd2, 5'd0, 1'b1);
        smp();
        chk("fwd_a_exmem", 32'(fa[0]), 32'd2);
        chk("fwd_b_x0", 32'(fb[0]), 32'd0);
        nxt();
        drive(OP_R, 3'b000, 7'h00, 5'd0, 5'd0, 5'd9, 1'b1);
        smp(); nxt();
        id_valid = 1'b0;
        smp();
        chk("x0_nofwd", 32'({fa[0], fb[0]}), 32'd0);
        nxt();
        smp();
        chk("x0_wb_regwrite", 32'(rw[0]), 32'd0);
        nxt();

        // redirect while a load-use condition is present
        do_reset();
        drive(OP_LW, 3'b010, 7'h00, 5'd1, 5'd0, 5'd5, 1'b1);
        smp(); nxt();
        drive(OP_R, 3'b000, 7'h00, 5'd5, 5'd1, 5'd6, 1'b1);
        ex_redirect = 1'b1;
        smp();
        chk("redir_flush", 32'(flush[0]), 32'd1);
        chk("redir_stall", 32'(stall[0]), 32'd0);
        nxt();
        ex_redirect = 1'b0; id_valid = 1'b0;
        smp();
        chk("redir_lw_advanced", 32'(mrd[0]), 32'd1);
        chk("redir_ex_bubble", 32'({aluop[0], src[0]}), 32'd0);
        nxt();
        smp();
        chk("redir_bubble1_mem", 32'({mrd[0], mwr[0]}), 32'd0);
        chk("redir_lw_wb", 32'({rw[0], m2r[0]}), 32'({1'b1, 2'b01}));
        nxt();
        smp();
        chk("redir_bubble2_mem", 32'({mrd[0], mwr[0]}), 32'd0);
        chk("redir_bubble1_wb", 32'(rw[0]), 32'd0);
        nxt();
        smp();
        chk("redir_bubble2_wb", 32'(rw[0]), 32'd0);
        nxt();

        // MEM_WAIT=3: LW then SW, each held in MEM four cycles
        do_reset();
        drive(OP_LW, 3'b010, 7'h00, 5'd1, 5'd0, 5'd5, 1'b1);
        smp(); nxt();
        drive(OP_SW, 3'b010, 7'h00, 5'd2, 5'd3, 5'd0, 1'b1);
        smp();
        chk("mw_busy_pre", 32'(busy[1]), 32'd0);
        nxt();
        id_valid = 1'b0;
        eb = 9'b001110111;
        er = 9'b000001111;
        ew = 9'b011110000;
        for (int k = 0; k < 9; k++) begin
            ex_redirect = (k == 1);
            smp();
            chk($sformatf("mw%0d_busy", k), 32'(busy[1]), 32'(eb[k]));
            chk($sformatf("mw%0d_read", k), 32'(mrd[1]), 32'(er[k]));
            chk($sformatf("mw%0d_write", k), 32'(mwr[1]), 32'(ew[k]));
            chk($sformatf("mw%0d_stall", k), 32'(stall[1]), 32'(eb[k]));
            if (k == 1) chk("mw_redirect_ignored", 32'(flush[1]), 32'd0);
            nxt();
        end
        ex_redirect = 1'b0;

        // reset during the freeze
        do_reset();
        drive(OP_LW, 3'b010, 7'h00, 5'd1, 5'd0, 5'd5, 1'b1);
        smp(); nxt();
        id_valid = 1'b0;
        smp(); nxt();
        smp();
        chk("mwr_busy_before", 32'(busy[1]), 32'd1);
        nxt();
        reset = 1'b1;
        smp();
        chk("mwr_busy_at_reset", 32'(busy[1]), 32'd1);
        nxt();
        smp();
        chk("mwr_busy_after", 32'(busy[1]), 32'd0);
        chk("mwr_read_after", 32'(mrd[1]), 32'd0);
        nxt();
        reset = 1'b0;

        // FWD_EN=0: RAW resolved by stalling until the producer retires
        do_reset();
        drive(OP_R, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 1'b1);
        smp(); nxt();
        drive(OP_R, 3'b000, 7'h20, 5'd3, 5'd3, 5'd4, 1'b1);
        for (int k = 0; k < 4; k++) begin
            smp();
            chk($sformatf("nf%0d_stall", k), 32'(stall[2]), 32'(k < 3));
            chk($sformatf("nf%0d_fwd", k), 32'({fa[2], fb[2]}), 32'd0);
            nxt();
        end
        id_valid = 1'b0;
        smp();
        chk("nf_sub_in_ex", 32'(aluop[2]), 32'd1);
        chk("nf_fwd_ex", 32'({fa[2], fb[2]}), 32'd0);
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
